// File: rtl/modmul_fermat_pipe.sv
// Modular multiplier for the Fermat-style modulus Q = 2^K + 1 (K = LOGQ-1).
// Three-stage pipeline: full product, one signed fold using 2^K = -1 (mod Q),
// then a final correction into 0..Q-1 with optional negation.
// A single global advance enable gives valid/ready flow control.
module modmul_fermat_pipe #(
    parameter int LOGQ = 17,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_a,
    input  logic [LOGQ-1:0] in_b,
    input  logic            in_op,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic [TAGW-1:0] out_tag
);

    localparam int K  = LOGQ - 1;
    localparam int PW = 2 * LOGQ;        // full product width, holds Q*Q
    localparam int HW = PW - K;          // width of the high product part
    localparam int TW = HW + 1;          // signed fold width: lo - hi never overflows

    localparam logic signed [TW-1:0] Q_S = TW'((64'd1 << K) + 64'd1);
    localparam logic [LOGQ-1:0]      Q_U = LOGQ'((64'd1 << K) + 64'd1);

    // Bring the signed fold into 0..Q-1. For legal operands the fold lies in
    // [-Q, Q-2], so one add suffices; the extra steps only bound illegal input.
    function automatic logic [LOGQ-1:0] fold_correct(input logic signed [TW-1:0] t);
        logic signed [TW-1:0] r;
        r = t;
        if (r < 0)
            r = r + Q_S;
        if (r < 0)
            r = r + Q_S;
        if (r >= Q_S)
            r = r - Q_S;
        return r[LOGQ-1:0];
    endfunction

    // Modular negation of a reduced value; zero stays zero so Q never appears.
    function automatic logic [LOGQ-1:0] negate_mod(input logic [LOGQ-1:0] r,
                                                   input logic            neg);
        if (neg && (r != '0))
            return Q_U - r;
        return r;
    endfunction

    logic en;

    logic [PW-1:0]        prod_p0;
    logic                 op_p0;
    logic [TAGW-1:0]      tag_p0;
    logic                 vld_p0;

    logic signed [TW-1:0] fold_p1;
    logic                 op_p1;
    logic [TAGW-1:0]      tag_p1;
    logic                 vld_p1;

    logic [LOGQ-1:0]      data_p2;
    logic [TAGW-1:0]      tag_p2;
    logic                 vld_p2;

    logic [PW-1:0]        prod_next;
    logic signed [TW-1:0] lo_s;
    logic signed [TW-1:0] hi_s;
    logic signed [TW-1:0] fold_next;

    assign en        = ~vld_p2 | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_tag   = tag_p2;

    // Product and first-fold arithmetic feeding the S1 and S2 registers.
    always_comb begin
        prod_next = PW'(in_a) * PW'(in_b);
        lo_s      = signed'({{(TW-K){1'b0}}, prod_p0[K-1:0]});
        hi_s      = signed'({1'b0, prod_p0[PW-1:K]});
        fold_next = lo_s - hi_s;
    end

    // Valid bits advance together under the global enable; reset flushes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // S1/S2 datapath registers; contents are ignored while their valid is low.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_p0 <= prod_next;
            op_p0   <= in_op;
            tag_p0  <= in_tag;
            fold_p1 <= fold_next;
            op_p1   <= op_p0;
            tag_p1  <= tag_p0;
        end
    end

    // S3 output register: corrected, optionally negated result with its tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p2 <= '0;
            tag_p2  <= '0;
        end else if (en) begin
            data_p2 <= negate_mod(fold_correct(fold_p1), op_p1);
            tag_p2  <= tag_p1;
        end
    end

endmodule

// File: tb/tb_modmul_fermat_pipe.sv
// Scoreboard bench for modmul_fermat_pipe at LOGQ = 17 (Q = 65537).
module tb_modmul_fermat_pipe;

    localparam int LOGQ = 17;
    localparam int TAGW = 4;
    localparam longint unsigned Q = 65537;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_a;
    logic [LOGQ-1:0] in_b;
    logic            in_op;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_data;
    logic [TAGW-1:0] out_tag;

    modmul_fermat_pipe #(.LOGQ(LOGQ), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOGQ-1:0] data;
        logic [TAGW-1:0] tag;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    bit   lat_chk = 1'b0;
    bit   stop_tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [LOGQ-1:0] model(input logic [LOGQ-1:0] a,
                                              input logic [LOGQ-1:0] b,
                                              input logic op);
        longint unsigned r;
        r = (longint'(a) * longint'(b)) % Q;
        if (op)
            r = (Q - r) % Q;
        return LOGQ'(r);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: push on acceptance, pop and compare on emission, watch stalls.
    initial begin
        bit              held = 1'b0;
        logic [LOGQ-1:0] hd;
        logic [TAGW-1:0] ht;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hd);
                    check("hold_tag", out_tag, ht);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("data", out_data, e.data);
                        check("tag", out_tag, e.tag);
                        if (lat_chk)
                            check("latency", cyc - e.cyc, 3);
                    end
                end
                if (in_valid && in_ready) begin
                    e.data = model(in_a, in_b, in_op);
                    e.tag  = in_tag;
                    e.cyc  = cyc;
                    sb.push_back(e);
                    acc_cnt++;
                end
                held = out_valid && !out_ready;
                hd   = out_data;
                ht   = out_tag;
            end
        end
    end

    task automatic send(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                        input logic op, input logic [TAGW-1:0] tag);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LOGQ-1:0] rand_opnd();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s == 0) return LOGQ'(Q);
        if (s == 1) return LOGQ'(Q - 1);
        if (s == 2) return '0;
        return LOGQ'($urandom_range(0, int'(Q)));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed corner values with latency checking.
        lat_chk = 1'b1;
        send(17'd65536, 17'd65536, 1'b0, 4'd1);
        drain();
        send(17'd2, 17'd32769, 1'b0, 4'd2);
        send(17'd1, 17'd5, 1'b1, 4'd3);
        send(17'd3, 17'd0, 1'b1, 4'd4);
        send(17'd65537, 17'd65537, 1'b0, 4'd5);
        send(17'd65537, 17'd65537, 1'b1, 4'd6);
        send(17'd65537, 17'd1, 1'b0, 4'd7);
        send(17'd65537, 17'd0, 1'b1, 4'd8);
        send(17'd65536, 17'd65535, 1'b1, 4'd9);
        drain();

        // Back-to-back random stream at full rate.
        for (int i = 0; i < 100; i++)
            send(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 4'(i));
        drain();

        // Output stall with four offered operations.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send(17'(t * 1000 + 7), 17'(t + 65530), 1'(t % 2), 4'(t));
            end
        join_none
        repeat (6) @(negedge clk);
        check("stall_accepted", acc_cnt - base, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_tag", out_tag, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        wait fork;
        check("stall_total", acc_cnt - base, 4);

        // Reset with two operations in flight.
        lat_chk = 1'b1;
        send(17'd12345, 17'd54321, 1'b0, 4'd10);
        send(17'd777, 17'd65536, 1'b1, 4'd11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_queue", sb.size(), 0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send(17'd40000, 17'd50000, 1'b1, 4'd12);
        drain();

        // Random backpressure over a long stream with random input gaps.
        lat_chk = 1'b0;
        fork
            begin
                while (!stop_tog) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join_none
        base = acc_cnt;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 4'(i));
        end
        stop_tog = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("rand_accepted", acc_cnt - base, 1000);
        check("final_queue", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
